vme_cmd_sequencer: RTL

Synthesizable, parametrised VME command player for on-board self-test and bring-up scripting. It holds a loadable list of up to DEPTH read/write commands and issues them one at a time to the VME command interface with a start/ready/response handshake. Read responses are returned on a result port with their list index, and a per-command response timeout aborts the run. It sits between the slow-control/test logic and the VME command/data registers.

---
 rtl/vme_cmd_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: plays a loaded list of VME read/write commands
// through a start/ready/response handshake with a response timeout.
module vme_cmd_sequencer #(
    parameter int          DEPTH   = 16,
    parameter int          AW      = $clog2(DEPTH),
    parameter int          DATA_W  = 16,
    parameter logic [31:0] MASK    = 32'h00A80000,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic              load_rw,
    input  logic [15:0]       load_cmd,
    input  logic [DATA_W-1:0] load_data,
    input  logic [AW:0]       num_cmds,
    input  logic              go,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [AW-1:0]     err_index,
    input  logic              vme_cmd_rd,
    input  logic              vme_dat_wr,
    input  logic [31:0]       vme_dat_reg_out,
    output logic              start,
    output logic [31:0]       vme_cmd_reg,
    output logic [31:0]       vme_dat_reg_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW-1:0]     rd_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT
    } state_t;

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_NONE  = '0;
    localparam logic [AW:0]   LP_NONE1 = (AW+1)'(1);
    localparam logic [AW-1:0] LP_IDX1  = AW'(1);
    localparam logic [15:0]   LP_TO    = 16'(TIMEOUT);

    logic              r_rw   [DEPTH];
    logic [15:0]       r_cmd  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_nxt;
    logic [AW:0]       r_n;
    logic [AW:0]       w_n_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;

    logic              w_start;
    logic [31:0]       w_cmd_reg;
    logic [31:0]       w_dat_in;
    logic              w_rd_valid;
    logic [DATA_W-1:0] w_rd_data;
    logic [AW-1:0]     w_rd_index;
    logic              w_done;
    logic              w_terr;
    logic [AW-1:0]     w_err_index;
    logic              w_busy;

    logic [AW:0]       w_eff_n;
    logic              w_last;
    logic              w_rw;
    logic [15:0]       w_cmd;
    logic [DATA_W-1:0] w_data;
    logic              w_unused_dat;

    assign w_eff_n = (num_cmds > LP_DEPTH) ? LP_DEPTH : num_cmds;
    assign w_last  = ({1'b0, r_idx} == (r_n - LP_NONE1));
    assign w_rw    = r_rw[r_idx];
    assign w_cmd   = r_cmd[r_idx];
    assign w_data  = r_data[r_idx];
    assign w_unused_dat = ^vme_dat_reg_out;

    // Command slot storage; deliberately survives reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            r_rw[load_addr]   <= load_rw;
            r_cmd[load_addr]  <= load_cmd;
            r_data[load_addr] <= load_data;
        end
    end

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_n_nxt     = r_n;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_cmd_reg   = MASK;
        w_dat_in    = 32'h0;
        w_rd_valid  = 1'b0;
        w_rd_data   = rd_data;
        w_rd_index  = rd_index;
        w_done      = 1'b0;
        w_terr      = timeout_err;
        w_err_index = err_index;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_terr = 1'b0;
                    if (w_eff_n != LP_NONE) begin
                        w_state_nxt = S_ISSUE;
                        w_idx_nxt   = '0;
                        w_n_nxt     = w_eff_n;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (vme_cmd_rd) begin
                    w_start     = 1'b1;
                    w_cmd_reg   = MASK | {6'b0, w_rw, ~w_rw, 8'h00, w_cmd};
                    w_dat_in    = 32'(w_data);
                    w_cnt_nxt   = 16'h0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response coincident with our own strobe is not ours.
                if (vme_dat_wr && !start) begin
                    w_state_nxt = S_NEXT;
                    if (w_rw) begin
                        w_rd_valid = 1'b1;
                        w_rd_data  = vme_dat_reg_out[DATA_W-1:0];
                        w_rd_index = r_idx;
                    end
                end else if (r_cnt >= LP_TO) begin
                    w_terr      = 1'b1;
                    w_err_index = r_idx;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_NEXT: begin
                if (w_last) begin
                    if (loop) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_idx_nxt   = r_idx + LP_IDX1;
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_n            <= '0;
            r_cnt          <= 16'h0;
            start          <= 1'b0;
            vme_cmd_reg    <= MASK;
            vme_dat_reg_in <= 32'h0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            rd_index       <= '0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            err_index      <= '0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_n            <= w_n_nxt;
            r_cnt          <= w_cnt_nxt;
            start          <= w_start;
            vme_cmd_reg    <= w_cmd_reg;
            vme_dat_reg_in <= w_dat_in;
            rd_valid       <= w_rd_valid;
            rd_data        <= w_rd_data;
            rd_index       <= w_rd_index;
            done           <= w_done;
            timeout_err    <= w_terr;
            err_index      <= w_err_index;
            busy           <= w_busy;
        end
    end

endmodule
